// File: rtl/coin_acceptor.sv
// ---------------------------------------------------------------------------
// coin_acceptor
//
// Front end for vending_machine. It synchronises and debounces the two raw
// coin sensors and turns each clean insertion into a coin event. Events are
// buffered in a small circular FIFO and drained onto `money` as one-cycle
// codes, with GAP_CYCLES idle cycles after each code. It also rejects
// simultaneous or overflow insertions and keeps a saturating credit total.
//
// Ports:
//   clk           rising-edge system clock
//   reset         asynchronous active-low reset (0 = reset)
//   coin_5        raw async sensor, high while a 5-unit coin passes
//   coin_10       raw async sensor, high while a 10-unit coin passes
//   credit_clr    synchronous clear of credit_total
//   money         2'b01 = 5 units, 2'b10 = 10 units, 2'b00 = nothing
//   coin_reject   one-cycle pulse when a coin is diverted to the return chute
//   fifo_full     registered level, FIFO holds FIFO_DEPTH entries
//   credit_total  saturating sum of emitted coin values
// ---------------------------------------------------------------------------
module coin_acceptor #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int GAP_CYCLES      = 2,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       coin_5,
  input  logic       coin_10,
  input  logic       credit_clr,
  output logic [1:0] money,
  output logic       coin_reject,
  output logic       fifo_full,
  output logic [7:0] credit_total
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  localparam logic [3:0]       DEB_LAST   = 4'(DEBOUNCE_CYCLES - 1);
  localparam logic [2:0]       GAP_LAST   = 3'(GAP_CYCLES);
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    GAP   = 2'd2
  } state_t;

  // Sensor vectors: bit 0 is the 5-unit sensor, bit 1 the 10-unit sensor.
  logic [1:0]      sync1_q, sync2_q;
  logic [1:0][3:0] deb_cnt_q, deb_cnt_d;
  logic [1:0]      level_q, level_d;
  logic [1:0]      level_prev_q;
  logic [1:0]      rise;

  logic [FIFO_DEPTH-1:0][1:0] mem_q, mem_d;
  logic [PTR_W-1:0]           wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]           rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]           count_q, count_d;
  logic                       fifo_full_q, fifo_full_d;

  logic       push, pop;
  logic [1:0] push_code;
  logic       reject_q, reject_d;

  state_t     state_q, state_d;
  logic [2:0] gap_cnt_q, gap_cnt_d;
  logic [1:0] money_q, money_d;
  logic       can_pop;

  logic [7:0] credit_q, credit_d;
  logic [7:0] credit_base;
  logic [8:0] credit_sum;
  logic [7:0] coin_value;

  // Debounce: a level only changes after the synchronised input has differed
  // from it for DEBOUNCE_CYCLES consecutive edges; any agreement restarts.
  always_comb begin
    deb_cnt_d = '0;
    level_d   = level_q;
    for (int i = 0; i < 2; i++) begin
      if (sync2_q[i] != level_q[i]) begin
        if (deb_cnt_q[i] == DEB_LAST) begin
          level_d[i] = ~level_q[i];
        end else begin
          deb_cnt_d[i] = deb_cnt_q[i] + 4'd1;
        end
      end
    end
  end

  // Rising edges of the debounced levels, seen one cycle after the toggle.
  assign rise = level_q & ~level_prev_q;

  // Event handling: simultaneous coins or a coin arriving while full are
  // rejected; otherwise the code is written into the FIFO.
  always_comb begin
    push      = 1'b0;
    push_code = 2'b00;
    reject_d  = 1'b0;
    if (rise[0] && rise[1]) begin
      reject_d = 1'b1;
    end else if (rise[0] || rise[1]) begin
      if (fifo_full_q) begin
        reject_d = 1'b1;
      end else begin
        push      = 1'b1;
        push_code = rise[0] ? 2'b01 : 2'b10;
      end
    end
  end

  // Output FSM. A pop is allowed from IDLE and on the edge that ends GAP,
  // which gives exactly GAP_CYCLES zero cycles between back-to-back codes.
  always_comb begin
    state_d   = state_q;
    gap_cnt_d = gap_cnt_q;
    money_d   = 2'b00;
    pop       = 1'b0;
    can_pop   = (state_q == IDLE) ||
                ((state_q == GAP) && (gap_cnt_q == GAP_LAST));
    case (state_q)
      IDLE: begin
        state_d = IDLE;
      end
      DRIVE: begin
        state_d   = GAP;
        gap_cnt_d = 3'd1;
      end
      GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          state_d = IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + 3'd1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (can_pop && (count_q != '0)) begin
      pop     = 1'b1;
      money_d = mem_q[rd_ptr_q];
      state_d = DRIVE;
    end
  end

  // FIFO bookkeeping; push and pop may coincide since a push is never
  // attempted while full.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q] = push_code;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    count_d     = count_q + CNT_W'(push) - CNT_W'(pop);
    fifo_full_d = (count_d == FULL_COUNT);
  end

  // Credit: clear first, then add the emitted coin, saturating at 255.
  always_comb begin
    credit_base = credit_clr ? 8'd0 : credit_q;
    coin_value  = (money_d == 2'b01) ? 8'd5 : 8'd10;
    credit_sum  = {1'b0, credit_base} + {1'b0, coin_value};
    credit_d    = credit_base;
    if (pop) begin
      credit_d = credit_sum[8] ? 8'hFF : credit_sum[7:0];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q      <= '0;
      sync2_q      <= '0;
      deb_cnt_q    <= '0;
      level_q      <= '0;
      level_prev_q <= '0;
      mem_q        <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      fifo_full_q  <= 1'b0;
      reject_q     <= 1'b0;
      state_q      <= IDLE;
      gap_cnt_q    <= '0;
      money_q      <= 2'b00;
      credit_q     <= '0;
    end else begin
      sync1_q      <= {coin_10, coin_5};
      sync2_q      <= sync1_q;
      deb_cnt_q    <= deb_cnt_d;
      level_q      <= level_d;
      level_prev_q <= level_q;
      mem_q        <= mem_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      fifo_full_q  <= fifo_full_d;
      reject_q     <= reject_d;
      state_q      <= state_d;
      gap_cnt_q    <= gap_cnt_d;
      money_q      <= money_d;
      credit_q     <= credit_d;
    end
  end

  assign money        = money_q;
  assign coin_reject  = reject_q;
  assign fifo_full    = fifo_full_q;
  assign credit_total = credit_q;

endmodule

// File: tb/tb_coin_acceptor.sv
// ---------------------------------------------------------------------------
// tb_coin_acceptor
//
// Scoreboard bench for coin_acceptor. A behavioural model turns the sampled
// sensor levels into expected emitted codes and rejects and queues them; a
// separate monitor compares them with what the DUT presents. The gap is set
// long enough that alternating coins can overrun the FIFO.
// ---------------------------------------------------------------------------
module tb_coin_acceptor;

  localparam int DEB   = 4;
  localparam int GAP   = 7;
  localparam int DEPTH = 4;

  logic       clk;
  logic       reset;
  logic       coin_5;
  logic       coin_10;
  logic       credit_clr;
  logic [1:0] money;
  logic       coin_reject;
  logic       fifo_full;
  logic [7:0] credit_total;

  coin_acceptor #(
    .DEBOUNCE_CYCLES(DEB),
    .GAP_CYCLES     (GAP),
    .FIFO_DEPTH     (DEPTH)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .coin_5      (coin_5),
    .coin_10     (coin_10),
    .credit_clr  (credit_clr),
    .money       (money),
    .coin_reject (coin_reject),
    .fifo_full   (fifo_full),
    .credit_total(credit_total)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int code;
    int credit;
    int edge_n;
  } exp_t;

  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  exp_t exp_q[$];
  int   rej_q[$];

  // Model state: sensor delay lines, debounced levels with their run of
  // disagreeing samples, pending rises, event FIFO and emission schedule.
  bit   pipe5[$];
  bit   pipe10[$];
  bit   m_lvl[2];
  int   m_run[2];
  bit   m_rise[2];
  int   m_fifo[$];
  int   m_next_ok;
  int   m_credit;
  bit   m_full;

  int   emit_count   = 0;
  int   rej_count    = 0;
  int   last_emit    = -1000;
  int   last_spacing = 0;
  bit   saw_full     = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] got,
                             input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s got %0d want %0d (edge %0d)", name, got, want, cyc);
    end
  endtask

  function automatic void model_reset();
    pipe5 = {};
    pipe10 = {};
    pipe5.push_back(1'b0);
    pipe5.push_back(1'b0);
    pipe10.push_back(1'b0);
    pipe10.push_back(1'b0);
    for (int i = 0; i < 2; i++) begin
      m_lvl[i]  = 1'b0;
      m_run[i]  = 0;
      m_rise[i] = 1'b0;
    end
    m_fifo    = {};
    m_next_ok = 0;
    m_credit  = 0;
    m_full    = 1'b0;
    exp_q     = {};
    rej_q     = {};
  endfunction

  // Reference model, evaluated once per rising edge with the values the DUT
  // samples on that edge.
  always @(posedge clk) begin : model_proc
    bit   s_used[2];
    bit   ev[2];
    int   pre_size;
    int   code;
    int   base;
    exp_t e;
    cyc++;
    if (!reset) begin
      model_reset();
    end else begin
      s_used[0] = pipe5.pop_front();
      s_used[1] = pipe10.pop_front();
      pipe5.push_back(coin_5);
      pipe10.push_back(coin_10);
      ev[0] = m_rise[0];
      ev[1] = m_rise[1];
      m_rise[0] = 1'b0;
      m_rise[1] = 1'b0;
      pre_size = m_fifo.size();
      if ((cyc >= m_next_ok) && (pre_size > 0)) begin
        code     = m_fifo.pop_front();
        base     = credit_clr ? 0 : m_credit;
        m_credit = base + ((code == 1) ? 5 : 10);
        if (m_credit > 255) m_credit = 255;
        m_next_ok = cyc + GAP + 1;
        e.code   = code;
        e.credit = m_credit;
        e.edge_n = cyc;
        exp_q.push_back(e);
      end else if (credit_clr) begin
        m_credit = 0;
      end
      if (ev[0] && ev[1]) begin
        rej_q.push_back(cyc);
      end else if (ev[0] || ev[1]) begin
        if (pre_size == DEPTH) rej_q.push_back(cyc);
        else m_fifo.push_back(ev[0] ? 1 : 2);
      end
      m_full = (m_fifo.size() == DEPTH);
      for (int i = 0; i < 2; i++) begin
        if (s_used[i] != m_lvl[i]) begin
          m_run[i]++;
          if (m_run[i] == DEB) begin
            m_lvl[i]  = s_used[i];
            m_run[i]  = 0;
            m_rise[i] = s_used[i];
          end
        end else begin
          m_run[i] = 0;
        end
      end
    end
  end

  // Monitor: compares the DUT against the scoreboard just after each edge.
  always @(posedge clk) begin : monitor_proc
    exp_t e;
    int   r;
    #1;
    checkOutput("fifo_full", fifo_full, m_full);
    checkOutput("credit_total", credit_total, m_credit);
    if (fifo_full) saw_full = 1'b1;
    if (money != 2'b00) begin
      emit_count++;
      last_spacing = cyc - last_emit;
      last_emit    = cyc;
      if (exp_q.size() == 0) begin
        checkOutput("money_unexpected", money, 0);
      end else begin
        e = exp_q.pop_front();
        checkOutput("money_code", money, e.code);
        checkOutput("money_edge", cyc, e.edge_n);
        checkOutput("money_credit", credit_total, e.credit);
      end
    end else if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checkOutput("money_missing", money, e.code);
    end
    if (coin_reject) begin
      rej_count++;
      if (rej_q.size() == 0) begin
        checkOutput("reject_unexpected", coin_reject, 0);
      end else begin
        r = rej_q.pop_front();
        checkOutput("reject_edge", cyc, r);
      end
    end else if (rej_q.size() > 0) begin
      r = rej_q.pop_front();
      checkOutput("reject_missing", coin_reject, 1);
    end
    if (!reset) last_emit = -1000;
  end

  // Drive the sensors/clear at a falling edge and hold for `cycles` cycles.
  task automatic applyStimulus(input bit c5, input bit c10, input bit clr,
                               input int cycles);
    coin_5     = c5;
    coin_10    = c10;
    credit_clr = clr;
    repeat (cycles) @(negedge clk);
  endtask

  // Holds coin_5 high from the current falling edge and returns the edge
  // index (1 = first edge sampling it high) at which money first appears.
  task automatic measureLatency(input int hold, output int first,
                                output int code);
    first = 0;
    code  = 0;
    coin_5 = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      @(posedge clk);
      #1;
      if ((money != 2'b00) && (first == 0)) begin
        first = k;
        code  = money;
      end
      if (k == hold) coin_5 = 1'b0;
    end
    @(negedge clk);
  endtask

  initial begin : stim
    int first, code, e0, r0, c0, n;
    reset      = 1'b0;
    coin_5     = 1'b0;
    coin_10    = 1'b0;
    credit_clr = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("rst_money", money, 0);
    checkOutput("rst_reject", coin_reject, 0);
    checkOutput("rst_full", fifo_full, 0);
    checkOutput("rst_credit", credit_total, 0);
    reset = 1'b1;
    repeat (3) @(negedge clk);

    $display("[TB] clean 5 coin");
    e0 = emit_count; r0 = rej_count;
    measureLatency(10, first, code);
    checkOutput("t1_latency", first, DEB + 4);
    checkOutput("t1_code", code, 1);
    checkOutput("t1_emits", emit_count - e0, 1);
    checkOutput("t1_rejects", rej_count - r0, 0);
    checkOutput("t1_credit", credit_total, 5);

    $display("[TB] bounce");
    applyStimulus(0, 0, 1, 1);
    checkOutput("t2_clear", credit_total, 0);
    e0 = emit_count;
    repeat (3) begin
      applyStimulus(1, 0, 0, 2);
      applyStimulus(0, 0, 0, 1);
    end
    applyStimulus(1, 0, 0, 6);
    applyStimulus(0, 0, 0, 30);
    checkOutput("t2_emits", emit_count - e0, 1);
    checkOutput("t2_credit", credit_total, 5);

    $display("[TB] simultaneous");
    e0 = emit_count; r0 = rej_count; c0 = credit_total;
    applyStimulus(1, 1, 0, 8);
    applyStimulus(0, 0, 0, 30);
    checkOutput("t3_rejects", rej_count - r0, 1);
    checkOutput("t3_emits", emit_count - e0, 0);
    checkOutput("t3_credit", credit_total, c0);

    $display("[TB] burst and overflow");
    e0 = emit_count; r0 = rej_count; saw_full = 1'b0;
    repeat (6) begin
      applyStimulus(1, 0, 0, 4);
      applyStimulus(0, 1, 0, 4);
    end
    applyStimulus(0, 0, 0, 3);
    checkOutput("t4_spacing", last_spacing, GAP + 1);
    applyStimulus(0, 0, 0, 60);
    checkOutput("t4_saw_full", saw_full, 1);
    checkOutput("t4_has_rejects", (rej_count - r0) > 0, 1);
    checkOutput("t4_accounted", (emit_count - e0) + (rej_count - r0), 12);

    $display("[TB] saturation and clear");
    applyStimulus(0, 0, 1, 1);
    repeat (26) begin
      applyStimulus(0, 1, 0, 4);
      applyStimulus(0, 0, 0, 4);
    end
    applyStimulus(0, 0, 0, 40);
    checkOutput("t5_saturated", credit_total, 255);
    coin_5 = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk);
      #1;
      if (k == 7) credit_clr = 1'b1;
      if (k == 8) begin
        credit_clr = 1'b0;
        checkOutput("t5_clr_code", money, 1);
        checkOutput("t5_clr_credit", credit_total, 5);
      end
    end
    @(negedge clk);
    applyStimulus(0, 0, 0, 30);

    $display("[TB] mid-operation reset");
    applyStimulus(1, 0, 0, 4);
    applyStimulus(0, 1, 0, 4);
    applyStimulus(1, 0, 0, 4);
    applyStimulus(0, 1, 0, 4);
    coin_10 = 1'b0;
    coin_5  = 1'b1;
    reset   = 1'b0;
    #1;
    checkOutput("t6_money", money, 0);
    checkOutput("t6_reject", coin_reject, 0);
    checkOutput("t6_full", fifo_full, 0);
    checkOutput("t6_credit", credit_total, 0);
    @(negedge clk);
    reset = 1'b1;
    e0 = emit_count;
    measureLatency(12, first, code);
    checkOutput("t6_latency", first, DEB + 4);
    checkOutput("t6_code", code, 1);
    applyStimulus(0, 0, 0, 20);
    checkOutput("t6_emits", emit_count - e0, 1);

    $display("[TB] random traffic");
    n = 0;
    repeat (300) begin
      applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    ($urandom_range(0, 15) == 0), $urandom_range(1, 9));
      n++;
    end
    applyStimulus(0, 0, 0, 80);
    checkOutput("end_exp_drained", exp_q.size(), 0);
    checkOutput("end_rej_drained", rej_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
